// File: rtl/tt06_sar_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tt06_sar_pkg
//  Brief    : Shared types and constants for the TT06 behavioural SAR ADC.
//  Revision : 1.0 - initial release
// ============================================================================
package tt06_sar_pkg;

  // Converter sequencing states
  typedef enum logic [1:0] {
    SAMPLE  = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int NBITS       = 8;
  localparam int CONV_CYCLES = 10;
  localparam int BIT_W       = $clog2(NBITS);

endpackage
`default_nettype wire

// File: rtl/tt06_sar_cdac_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : tt06_sar_cdac_cmp
//  Brief    : Ideal capacitive DAC plus comparator. Decides whether the held
//             differential sample is at or above the DAC level for a trial
//             code.
//  Revision : 1.0 - initial release
// ============================================================================
module tt06_sar_cdac_cmp
  import tt06_sar_pkg::*;
#(
  parameter real VFS = 1.8
) (
  input  real              i_vs,
  input  logic [NBITS-1:0] i_trial,
  output logic             o_ge
);

  // Tolerance far below one LSB so that a sample landing exactly on a
  // threshold still resolves upward despite double-precision rounding of
  // the DAC arithmetic (e.g. 192*3.6/256-1.8 evaluating a hair above 0.9).
  localparam real c_EPS = 1.0e-12;

  real w_vdac;

  // DAC level for the trial code, then the comparator decision
  always_comb begin
    w_vdac = (real'(i_trial) * 2.0 * VFS / 256.0) - VFS;
    o_ge   = (i_vs >= (w_vdac - c_EPS));
  end

endmodule
`default_nettype wire

// File: rtl/tt_um_tt06_sar_wulffern.sv
`default_nettype none
// ============================================================================
//  Module   : tt_um_tt06_sar_wulffern
//  Brief    : TT06 tile with a free-running 8-bit differential SAR ADC.
//             One conversion every 10 clocks: sample, 8 bit trials, publish.
//  Revision : 1.0 - initial release
// ============================================================================
module tt_um_tt06_sar_wulffern
  import tt06_sar_pkg::*;
#(
  parameter real VFS = 1.8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       VGND,
  input  logic       VPWR,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  real        ua_0,
  input  real        ua_1,
  input  logic       ena
);

  state_t             r_state, w_state_nxt;
  logic [BIT_W-1:0]   r_bit,   w_bit_nxt;
  logic [NBITS-1:0]   r_code,  w_code_nxt;
  logic [NBITS-1:0]   r_uo,    w_uo_nxt;
  real                r_vs,    w_vs_nxt;
  logic [NBITS-1:0]   w_trial;
  logic               w_ge;

  // Harness pins with no functional role; collected only to keep lint quiet
  logic w_unused;
  assign w_unused = ^{VGND, VPWR, ui_in, uio_in, ena};

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
  assign uo_out  = r_uo;

  // Current trial code: accepted bits so far plus the bit under test
  assign w_trial = r_code | (NBITS'(1) << r_bit);

  tt06_sar_cdac_cmp #(
    .VFS     (VFS)
  ) u_cdac_cmp (
    .i_vs    (r_vs),
    .i_trial (w_trial),
    .o_ge    (w_ge)
  );

  // State, SAR and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SAMPLE;
      r_bit   <= BIT_W'(NBITS - 1);
      r_code  <= '0;
      r_uo    <= '0;
      r_vs    <= 0.0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_code  <= w_code_nxt;
      r_uo    <= w_uo_nxt;
      r_vs    <= w_vs_nxt;
    end
  end

  // Next-state logic: sample, binary search MSB to LSB, then publish
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_code_nxt  = r_code;
    w_uo_nxt    = r_uo;
    w_vs_nxt    = r_vs;
    case (r_state)
      SAMPLE: begin
        w_vs_nxt    = ua_0 - ua_1;
        w_code_nxt  = '0;
        w_bit_nxt   = BIT_W'(NBITS - 1);
        w_state_nxt = CONVERT;
      end
      CONVERT: begin
        if (w_ge) begin
          w_code_nxt = w_trial;
        end
        if (r_bit == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_bit_nxt = r_bit - BIT_W'(1);
        end
      end
      DONE: begin
        w_uo_nxt    = r_code;
        w_state_nxt = SAMPLE;
      end
      default: begin
        w_state_nxt = SAMPLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_tt06_sar_wulffern.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tt_um_tt06_sar_wulffern
//  Brief    : Directed self-checking bench for the TT06 SAR ADC tile.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tt_um_tt06_sar_wulffern;

  logic       clk;
  logic       rst_n;
  logic       VGND;
  logic       VPWR;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  real        ua_0;
  real        ua_1;
  logic       ena;

  int n_assert;
  int n_fail;

  tt_um_tt06_sar_wulffern dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .VGND    (VGND),
    .VPWR    (VPWR),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ua_0    (ua_0),
    .ua_1    (ua_1),
    .ena     (ena)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply a differential input at the SAMPLE edge and check the result
  // published 10 edges later; assumes the previous edge was a DONE edge.
  task automatic conv(input string tag, input real vp, input real vn, input logic [7:0] exp);
    ua_0 = vp;
    ua_1 = vn;
    for (int i = 0; i < 10; i++) tick();
    chk(tag, uo_out, exp);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    VGND     = 1'b0;
    VPWR     = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    ena      = 1'b1;
    ua_0     = 0.0;
    ua_1     = 0.0;
    rst_n    = 1'b0;

    // Reset state
    #12;
    chk("rst_uo",     uo_out,  8'h00);
    chk("rst_uio_oe", uio_oe,  8'h00);
    chk("rst_uio_out",uio_out, 8'h00);

    // Release between edges (edge at 15 ns is the first after release)
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("pre_result_edge%0d", i), uo_out, 8'h00);
    end
    tick();
    chk("zero_first", uo_out, 8'h80);

    // Zero differential stays at mid-code across updates
    for (int k = 0; k < 4; k++) begin
      conv($sformatf("zero_repeat%0d", k), 0.0, 0.0, 8'h80);
    end

    // Full scale, negative full scale, half positive scale
    conv("pos_full",  1.8, 0.0, 8'hFF);
    conv("neg_full",  0.0, 1.8, 8'h00);
    conv("half_pos",  0.9, 0.0, 8'hC0);
    conv("neg_over", -1.0, 1.5, 8'h00);
    conv("pos_over",  2.0, 0.0, 8'hFF);
    // Code 0x40 boundary: -0.9 V
    conv("quarter",   0.0, 0.9, 8'h40);

    // Threshold of code 1, and 1 mV beneath it
    conv("thr_code1", 1.0 * 2.0 * 1.8 / 256.0 - 1.8, 0.0, 8'h01);
    conv("thr_below", 1.0 * 2.0 * 1.8 / 256.0 - 1.8 - 0.001, 0.0, 8'h00);

    // Input step during CONVERT cycle 3 must not affect current conversion
    ua_0 = 0.0;
    ua_1 = 0.0;
    for (int i = 0; i < 3; i++) tick();
    ua_0 = 1.8;
    for (int i = 0; i < 6; i++) tick();
    chk("step_hold_prev", uo_out, 8'h00);
    tick();
    chk("step_current", uo_out, 8'h80);
    for (int i = 0; i < 10; i++) tick();
    chk("step_next", uo_out, 8'hFF);

    // Async reset at conversion cycle 5 with ena/ui_in floating
    ena   = 1'bz;
    ui_in = 8'hzz;
    uio_in = 8'hxx;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_abort_hold", uo_out, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_uo", uo_out, 8'h00);
    #4 rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 9) chk("rerelease_edge9", uo_out, 8'h00);
    end
    tick();
    chk("rerelease_edge10", uo_out, 8'hFF);
    chk("end_uio_oe",  uio_oe,  8'h00);
    chk("end_uio_out", uio_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_um_tt06_sar_wulffern.md
Name: tt_um_tt06_sar_wulffern

Overview:
- TinyTapeout (TT06) user tile holding a free-running 8-bit differential successive-approximation ADC.
- Behavioural model: the two analog pins are real-valued inputs. Sampling, binary search against an ideal capacitive DAC and the comparator are modelled cycle-accurately.
- The latest completed conversion result is presented on uo_out.
- Sits directly under the TT harness; no other digital blocks are involved.

Parameters:
- VFS, 1.8 (real): differential full-scale magnitude in volts; input range is -VFS to +VFS.
- NBITS, 8: resolution; fixed at 8 to match uo_out.

Ports:
- clk  input  1  system clock (100 MHz nominal)
- rst_n  input  1  asynchronous, active-low reset
- VGND  input  1  ground supply pin; connectivity only, no functional effect
- VPWR  input  1  power supply pin; connectivity only, no functional effect
- ui_in  input  8  reserved, ignored (may be X/Z)
- uo_out  output  8  last completed conversion code, offset binary
- uio_in  input  8  ignored
- uio_out  output  8  constant 0x00
- uio_oe  output  8  constant 0x00 (all bidirectional pins inputs)
- ua_0  input  real  positive analog input VIP (volts)
- ua_1  input  real  negative analog input VIN (volts)
- ena  input  1  TT tile enable; ignored, conversion runs regardless (may be X/Z)

Behaviour:
- Reset (rst_n=0, async): state=SAMPLE, bit index=7, trial code=0x00, held sample=0.0, uo_out=0x00. uio_out/uio_oe are always 0x00.
- Sequencing is free-running on clk rising edges after reset release. One conversion takes 10 cycles.
- SAMPLE (1 cycle): vs <= ua_0 - ua_1. Code register <= 0x00. Bit index <= 7. Next state CONVERT.
- CONVERT (8 cycles, bit index 7 down to 0), per cycle:
  - trial = code | (1<<i).
  - vdac = trial*2*VFS/256 - VFS.
  - If vs >= vdac, code <= trial; else code unchanged.
  - Decrement i. After i=0, go to DONE.
- DONE (1 cycle): uo_out <= code. Next state SAMPLE.
- uo_out is updated only in DONE and holds its value for the remaining 9 cycles.
- First valid result appears on the 10th rising edge after rst_n deasserts. Subsequent results follow every 10 cycles.
- Transfer function: code = floor((vs+VFS)*256/(2*VFS)), saturating.
  - vs >= VFS*(254/256) gives 0xFF.
  - vs < -VFS*(254/256) gives 0x00; any vs <= -VFS gives 0x00.
  - vs exactly on a threshold resolves upward (comparator uses >=).
- Inputs change only matter at the SAMPLE edge. Changes during CONVERT/DONE do not affect the current conversion.
- Reset mid-conversion aborts it; uo_out returns to 0x00 immediately.
- Power pins, ui_in, uio_in and ena have no functional influence, including when X/Z.

Decomposition:
- Package tt06_sar_pkg:
  - state enum {SAMPLE, CONVERT, DONE}
  - NBITS=8
  - CONV_CYCLES=10
- One sub-module is natural: tt06_sar_cdac_cmp.
  - Inputs: real vs, 8-bit trial, real VFS parameter.
  - Output: 1-bit comparator decision, combinational.
  - It models the ideal CDAC plus comparator.
- The top keeps the FSM, the successive-approximation register and the output register.

Test Plan:
- Reset: hold rst_n=0 for 10 ns, ua_0=ua_1=0.0 -> uo_out=0x00, uio_oe=0x00, uio_out=0x00 while in reset and for the first 9 cycles after release.
- Zero differential: ua_0=ua_1=0.0, run 2600 ns -> uo_out=0x80 from the 10th edge after release; stays 0x80 every 10-cycle update.
- Full scale: ua_0=1.8, ua_1=0.0 -> 0xFF. ua_0=0.0, ua_1=1.8 -> 0x00. ua_0=0.9, ua_1=0.0 -> 0xC0.
- Threshold: vs = 1*2*1.8/256 - 1.8 (code-1 boundary) -> 0x01; vs 1 mV below -> 0x00.
- Input change mid-conversion: ua_0 steps from 0.0 to 1.8 during CONVERT cycle 3 -> current result 0x80, next result 0xFF.
- Async reset at conversion cycle 5 with ena/ui_in left Z -> uo_out=0x00 immediately; first new result exactly 10 edges after re-release.
